// File: rtl/intr_ctrl_if.sv
// Commit-stage interrupt handshake: held request plus masked vector, and the acceptance strobe.
interface intr_ctrl_if;
  logic       int_req;
  logic [7:0] int_vector;
  logic       int_ack;

  modport master (output int_req, output int_vector, input int_ack);
  modport slave  (input int_req, input int_vector, output int_ack);
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt front-end: sync + glitch-filter hw lines, merge timer, drive Cause.IP and a held commit request.
// hw edge -> interrupt_flag in SYNC_STAGES+FILTER_CYCLES+1 edges; request held until int_ack or withdrawn.
module intr_ctrl #(
  parameter int HW_INT_NUM    = 6,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  input  logic                  timer_int,
  input  logic                  status_ie,
  input  logic                  status_exl,
  input  logic                  status_erl,
  input  logic [7:0]            status_im,
  input  logic [1:0]            cause_ip_sw,
  output logic [7:0]            interrupt_flag,
  intr_ctrl_if.master           req
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_EXL} state_t;

  logic [HW_INT_NUM-1:0] sync_q [SYNC_STAGES];
  logic [HW_INT_NUM-1:0] sync;
  logic [HW_INT_NUM-1:0] filt;
  logic [5:0]            filt6;
  logic [7:0]            pending;
  logic                  take;

  state_t     state, state_nxt;
  logic       int_req_nxt;
  logic [7:0] int_vector_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= hw_int_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign filt = sync;
    end else begin : g_filt
      localparam int CW = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
      for (genvar i = 0; i < HW_INT_NUM; i++) begin : g_line
        logic [CW-1:0] cnt;
        logic          filt_bit;
        // Any return to the filtered level restarts the stability count.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            cnt      <= '0;
            filt_bit <= 1'b0;
          end else if (sync[i] == filt_bit) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            filt_bit <= sync[i];
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        assign filt[i] = filt_bit;
      end
    end
  endgenerate

  generate
    for (genvar i = 0; i < 6; i++) begin : g_pad
      if (i < HW_INT_NUM) begin : g_used
        assign filt6[i] = filt[i];
      end else begin : g_unused
        assign filt6[i] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) interrupt_flag <= 8'h00;
    else      interrupt_flag <= {filt6[5] | timer_int, filt6[4:0], 2'b00};
  end

  assign pending = {interrupt_flag[7:2], cause_ip_sw} & status_im;
  assign take    = (pending != 8'h00) & status_ie & ~status_exl & ~status_erl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      req.int_req    <= 1'b0;
      req.int_vector <= 8'h00;
    end else begin
      state          <= state_nxt;
      req.int_req    <= int_req_nxt;
      req.int_vector <= int_vector_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    int_req_nxt    = 1'b0;
    int_vector_nxt = 8'h00;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt      = REQ;
          int_req_nxt    = 1'b1;
          int_vector_nxt = pending;
        end
      end
      REQ: begin
        // Acceptance beats a same-cycle withdrawal so the handler is never lost.
        if (req.int_ack) begin
          state_nxt = WAIT_EXL;
        end else if (!take) begin
          state_nxt = IDLE;
        end else begin
          int_req_nxt    = 1'b1;
          int_vector_nxt = pending;
        end
      end
      WAIT_EXL: begin
        // Hold off re-requesting until the exception entry has set EXL/ERL.
        if (status_exl | status_erl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: filter latency, timer merge, handshake, withdraw and async reset.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] hw_int_i;
  logic       timer_int, status_ie, status_exl, status_erl;
  logic [7:0] status_im;
  logic [1:0] cause_ip_sw;
  logic [7:0] interrupt_flag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  intr_ctrl_if req_if ();

  intr_ctrl #(.HW_INT_NUM(6), .SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .hw_int_i       (hw_int_i),
    .timer_int      (timer_int),
    .status_ie      (status_ie),
    .status_exl     (status_exl),
    .status_erl     (status_erl),
    .status_im      (status_im),
    .cause_ip_sw    (cause_ip_sw),
    .interrupt_flag (interrupt_flag),
    .req            (req_if)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({interrupt_flag, req_if.int_req, req_if.int_vector} !== 17'h0) begin
      n_err++;
      $display("FAIL reset_state: got flag=%h req=%b vec=%h, need all 0", interrupt_flag, req_if.int_req, req_if.int_vector);
    end
    rst = 1'b1;
  endtask

  task automatic test_pulse();
    status_ie = 1'b1;
    status_im = 8'h04;
    @(negedge clk);
    hw_int_i[0] = 1'b1;
    repeat (2) @(negedge clk);
    hw_int_i[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({interrupt_flag, req_if.int_req} !== 9'h0) begin
        n_err++;
        $display("FAIL pulse_filtered cyc%0d: got flag=%h req=%b, need 00/0", k, interrupt_flag, req_if.int_req);
      end
    end
  endtask

  task automatic test_hold_latency();
    logic [7:0] exp_flag;
    @(negedge clk);
    hw_int_i[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_flag = (k == 6) ? 8'h04 : 8'h00;
      n_cmp++;
      if (interrupt_flag !== exp_flag) begin
        n_err++;
        $display("FAIL hold_latency edge%0d: got flag=%h, need %h", k, interrupt_flag, exp_flag);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b1 || req_if.int_vector !== 8'h04) begin
      n_err++;
      $display("FAIL hw_request: got req=%b vec=%h, need 1/04", req_if.int_req, req_if.int_vector);
    end
    repeat (3) @(negedge clk);
    hw_int_i[0] = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({interrupt_flag, req_if.int_req} !== 9'h0) begin
      n_err++;
      $display("FAIL hw_release: got flag=%h req=%b, need 00/0", interrupt_flag, req_if.int_req);
    end
  endtask

  task automatic test_timer();
    @(negedge clk);
    timer_int = 1'b1;
    status_im = 8'h80;
    @(negedge clk);
    n_cmp++;
    if (interrupt_flag !== 8'h80 || req_if.int_req !== 1'b0) begin
      n_err++;
      $display("FAIL timer_flag: got flag=%h req=%b, need 80/0", interrupt_flag, req_if.int_req);
    end
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b1 || req_if.int_vector !== 8'h80) begin
      n_err++;
      $display("FAIL timer_req: got req=%b vec=%h, need 1/80", req_if.int_req, req_if.int_vector);
    end
  endtask

  task automatic test_handshake();
    req_if.int_ack = 1'b1;
    @(negedge clk);
    req_if.int_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (req_if.int_req !== 1'b0) begin
        n_err++;
        $display("FAIL ack_gap cyc%0d: got req=%b, need 0", k, req_if.int_req);
      end
      if (k < 2) @(negedge clk);
    end
    status_exl = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b0) begin
      n_err++;
      $display("FAIL exl_block: got req=%b, need 0", req_if.int_req);
    end
    status_exl = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b1 || req_if.int_vector !== 8'h80) begin
      n_err++;
      $display("FAIL rerequest: got req=%b vec=%h, need 1/80", req_if.int_req, req_if.int_vector);
    end
  endtask

  task automatic test_withdraw();
    status_ie = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b0 || req_if.int_vector !== 8'h00) begin
      n_err++;
      $display("FAIL withdraw: got req=%b vec=%h, need 0/00", req_if.int_req, req_if.int_vector);
    end
    status_ie = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b1 || req_if.int_vector !== 8'h80) begin
      n_err++;
      $display("FAIL withdraw_idle: got req=%b vec=%h, need 1/80", req_if.int_req, req_if.int_vector);
    end
  endtask

  task automatic test_simultaneous();
    req_if.int_ack = 1'b1;
    status_im = 8'h00;
    @(negedge clk);
    req_if.int_ack = 1'b0;
    status_im = 8'h80;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_if.int_req !== 1'b0) begin
        n_err++;
        $display("FAIL simul_wait cyc%0d: got req=%b, need 0", k, req_if.int_req);
      end
    end
    status_exl = 1'b1;
    @(negedge clk);
    status_exl = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b1) begin
      n_err++;
      $display("FAIL simul_rerequest: got req=%b, need 1", req_if.int_req);
    end
  endtask

  task automatic test_sw_int();
    status_ie = 1'b0;
    timer_int = 1'b0;
    @(negedge clk);
    @(negedge clk);
    status_im   = 8'h01;
    cause_ip_sw = 2'b01;
    status_ie   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b1 || req_if.int_vector !== 8'h01 || interrupt_flag !== 8'h00) begin
      n_err++;
      $display("FAIL sw_int: got req=%b vec=%h flag=%h, need 1/01/00", req_if.int_req, req_if.int_vector, interrupt_flag);
    end
    cause_ip_sw = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b0 || req_if.int_vector !== 8'h00) begin
      n_err++;
      $display("FAIL sw_drop: got req=%b vec=%h, need 0/00", req_if.int_req, req_if.int_vector);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_flag;
    status_im   = 8'h04;
    hw_int_i[0] = 1'b1;
    repeat (7) @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b1 || req_if.int_vector !== 8'h04) begin
      n_err++;
      $display("FAIL pre_reset_req: got req=%b vec=%h, need 1/04", req_if.int_req, req_if.int_vector);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({interrupt_flag, req_if.int_req, req_if.int_vector} !== 17'h0) begin
      n_err++;
      $display("FAIL async_reset: got flag=%h req=%b vec=%h, need all 0", interrupt_flag, req_if.int_req, req_if.int_vector);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_flag = (k == 6) ? 8'h04 : 8'h00;
      n_cmp++;
      if (interrupt_flag !== exp_flag) begin
        n_err++;
        $display("FAIL post_reset_latency edge%0d: got flag=%h, need %h", k, interrupt_flag, exp_flag);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (req_if.int_req !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_req: got req=%b, need 1", req_if.int_req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    hw_int_i       = '0;
    timer_int      = 1'b0;
    status_ie      = 1'b0;
    status_exl     = 1'b0;
    status_erl     = 1'b0;
    status_im      = 8'h00;
    cause_ip_sw    = 2'b00;
    req_if.int_ack = 1'b0;

    test_reset();
    test_pulse();
    test_hold_latency();
    test_timer();
    test_handshake();
    test_withdraw();
    test_simultaneous();
    test_sw_int();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt front-end that sits directly upstream of the CP0 register file.
- Synchronises and glitch-filters the asynchronous hardware interrupt lines, then merges in the CP0 timer interrupt.
- Drives the interrupt_flag vector that CP0 loads into Cause.IP[7:2].
- Computes the masked and enabled interrupt condition, and raises a held request to the commit/exception stage until that stage accepts it or the condition goes away.

Parameters:
- HW_INT_NUM, 6, number of hardware interrupt lines; they map to IP2..IP7.
- SYNC_STAGES, 2, depth of the per-line synchroniser flop chain; legal values are 2..4.
- FILTER_CYCLES, 3, number of consecutive stable synchronised cycles needed before a filtered line changes; 0 bypasses the filter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- hw_int_i  in  HW_INT_NUM  asynchronous level-sensitive interrupt lines, active-high.
- timer_int  in  1  CP0 compare-match interrupt, synchronous to clk.
- status_ie  in  1  Status.IE.
- status_exl  in  1  Status.EXL.
- status_erl  in  1  Status.ERL.
- status_im  in  8  Status.IM[7:0].
- cause_ip_sw  in  2  Cause.IP[1:0], the software interrupt bits.
- interrupt_flag  out  8  interrupt vector to CP0; bits [1:0] are always 0.
- int_req  out  1  interrupt request to the commit stage.
- int_vector  out  8  masked pending bits accompanying int_req.
- int_ack  in  1  commit stage accepted the interrupt this cycle.

Behaviour:
- Reset (rst=0, asynchronous): clear all synchroniser flops, filter counters, filtered lines, interrupt_flag, int_req and int_vector to 0; FSM goes to IDLE.
- Synchroniser: SYNC_STAGES flops per line, no combinational path from hw_int_i.
- Filter, per line, counter width $clog2(FILTER_CYCLES+1):
  - If the synchronised value equals the filtered value, clear the counter.
  - Otherwise increment the counter. When it reaches FILTER_CYCLES, the filtered value takes the synchronised value and the counter clears.
  - A pulse shorter than FILTER_CYCLES synchronised cycles never reaches the filtered value.
  - FILTER_CYCLES=0: filtered value = synchronised value.
- interrupt_flag (registered):
  - [6:2] = filt[4:0].
  - [7] = filt[5] | timer_int.
  - [1:0] = 0.
  - If HW_INT_NUM<6, the unused filt bits read as 0.
- Latency from a hw_int_i edge to interrupt_flag: SYNC_STAGES+FILTER_CYCLES+1 rising edges. From timer_int to interrupt_flag[7]: 1 edge.
- pending = {interrupt_flag[7:2], cause_ip_sw} & status_im.
- take = (pending != 0) & status_ie & ~status_exl & ~status_erl.
- FSM states: IDLE, REQ, WAIT_EXL.
- IDLE:
  - take=1 -> REQ. int_req=1 from the next cycle; int_vector <= pending.
- REQ:
  - int_req is held at 1, and int_vector updates to the current pending every cycle.
  - int_ack=1 -> WAIT_EXL, and int_req drops the next cycle.
  - int_ack=0 and take=0 -> IDLE, int_req drops, int_vector <= 0 (request withdrawn).
  - int_ack and take falling in the same cycle: int_ack wins, go to WAIT_EXL.
- WAIT_EXL:
  - int_req=0.
  - status_exl | status_erl = 1 -> IDLE.
  - This state blocks a duplicate request in the gap between ack and EXL being set.
- int_ack while in IDLE or WAIT_EXL is ignored.
- Reset mid-request: int_req drops immediately (asynchronously), and the FSM is in IDLE when reset is released.
- Software interrupts (cause_ip_sw) bypass the synchroniser and filter. Latency from cause_ip_sw to int_req is 1 edge.

Test Plan:
- Pulse check: FILTER_CYCLES=3, SYNC_STAGES=2, mask enabled.
  - hw_int_i[0] high for 2 cycles -> interrupt_flag stays 8'h00, int_req stays 0.
  - Held high for 10 cycles -> interrupt_flag=8'h04 exactly 6 edges after the rise.
- Timer merge: timer_int=1, status_im=8'h80, ie=1, exl=0 -> interrupt_flag=8'h80 after 1 edge, int_req=1 after 2 edges, int_vector=8'h80.
- Handshake:
  - In REQ, assert int_ack for 1 cycle with exl held 0 for 3 cycles -> int_req stays 0 for those cycles.
  - Then set exl=1 and later clear it with the source still pending -> int_req re-asserts 1 cycle after exl=0.
- Withdraw: in REQ, clear status_ie with no int_ack -> int_req=0 and int_vector=8'h00 the next cycle, FSM back in IDLE.
- Simultaneous: int_ack=1 in the same cycle status_im goes to 8'h00 -> FSM goes to WAIT_EXL, not IDLE; no re-request until exl has been seen.
- Async reset: drop rst mid-REQ between clock edges -> int_req=0 and interrupt_flag=8'h00 without a clock edge; after release, the line must pass the full sync+filter latency again.
